// File: rtl/parking_pkg.sv
// parking_pkg: shared types, constants and plate validation for the parking lot front-end
package parking_pkg;
    localparam int PLATE_W = 16;
    localparam logic DIR_IN = 1'b0;
    localparam logic DIR_OUT = 1'b1;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_HOLD} gate_q_state_t;
    typedef struct packed {
        logic               dir;
        logic [PLATE_W-1:0] plate;
    } gate_req_t;
    // A plate is four BCD digits and may not be all zeros
    function automatic logic plate_is_valid(input logic [PLATE_W-1:0] plate);
        logic ok;
        ok = plate != '0;
        for (int i = 0; i < PLATE_W / 4; i++)
            if (plate[i*4 +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction
endpackage

// File: rtl/gate_request_queue_if.sv
// gate_request_queue_if: gate reader request handshake and lot dispatch signals
interface gate_request_queue_if #(parameter int DEPTH = 4) ();
    logic                    req_valid;
    logic                    req_dir;
    logic [15:0]             req_plate;
    logic                    req_ready;
    logic                    lot_busy;
    logic                    leakage;
    logic [15:0]             license_plate;
    logic                    in_mode;
    logic                    out_mode;
    logic                    reject;
    logic [$clog2(DEPTH):0]  queue_count;
    logic                    full;
    logic                    empty;
    modport master (
        output req_valid, req_dir, req_plate, lot_busy, leakage,
        input  req_ready, license_plate, in_mode, out_mode, reject, queue_count, full, empty
    );
    modport slave (
        input  req_valid, req_dir, req_plate, lot_busy, leakage,
        output req_ready, license_plate, in_mode, out_mode, reject, queue_count, full, empty
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: circular buffer whose pointers carry an extra wrap bit so full and empty are distinct
module sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr, r_rd;
    logic             w_push, w_pop;
    assign o_count = r_wr - r_rd;
    assign o_full  = o_count == (AW+1)'(DEPTH);
    assign o_empty = o_count == '0;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd[AW-1:0]];
    always_ff @(posedge i_clock or negedge i_reset_n)
        if (!i_reset_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            r_wr <= r_wr + (AW+1)'(w_push);
            r_rd <= r_rd + (AW+1)'(w_pop);
        end
    always_ff @(posedge i_clock)
        if (w_push) r_mem[r_wr[AW-1:0]] <= i_wdata;
endmodule

// File: rtl/gate_request_queue.sv
// gate_request_queue: buffers gate requests and replays them to the lot as one-cycle mode pulses
module gate_request_queue
    import parking_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int HOLDOFF = 2
) (
    input logic                 i_clock,
    input logic                 i_reset_n,
    gate_request_queue_if.slave bus
);
    gate_q_state_t          r_state;
    logic [3:0]             r_hold;
    logic                   r_in_mode, r_out_mode, r_reject;
    logic [PLATE_W-1:0]     r_plate;
    gate_req_t              w_wdata, w_head;
    logic                   w_push, w_store, w_pop, w_full, w_empty;
    logic [$clog2(DEPTH):0] w_count;
    assign w_push  = bus.req_valid && bus.req_ready;
    assign w_store = w_push && plate_is_valid(bus.req_plate);
    assign w_wdata = '{dir: bus.req_dir, plate: bus.req_plate};
    // Leakage and lot_busy only gate the decision to start; an ISSUE in flight always completes
    assign w_pop   = r_state == ST_IDLE && !w_empty && !bus.lot_busy && !bus.leakage;
    sync_fifo #(.WIDTH($bits(gate_req_t)), .DEPTH(DEPTH)) u_fifo (
        .i_clock  (i_clock),
        .i_reset_n(i_reset_n),
        .i_push   (w_store),
        .i_wdata  (w_wdata),
        .i_pop    (w_pop),
        .o_rdata  (w_head),
        .o_count  (w_count),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );
    assign bus.req_ready     = !w_full;
    assign bus.queue_count   = w_count;
    assign bus.full          = w_full;
    assign bus.empty         = w_empty;
    assign bus.in_mode       = r_in_mode;
    assign bus.out_mode      = r_out_mode;
    assign bus.reject        = r_reject;
    assign bus.license_plate = r_plate;
    always_ff @(posedge i_clock or negedge i_reset_n)
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_hold     <= '0;
            r_in_mode  <= 1'b0;
            r_out_mode <= 1'b0;
            r_reject   <= 1'b0;
            r_plate    <= '0;
        end else begin
            r_reject <= w_push && !w_store;
            case (r_state)
                ST_IDLE: if (w_pop) begin
                    r_state    <= ST_ISSUE;
                    r_in_mode  <= w_head.dir == DIR_IN;
                    r_out_mode <= w_head.dir == DIR_OUT;
                    r_plate    <= w_head.plate;
                end
                ST_ISSUE: begin
                    r_state    <= ST_HOLD;
                    r_hold     <= 4'd1;
                    r_in_mode  <= 1'b0;
                    r_out_mode <= 1'b0;
                    r_plate    <= '0;
                end
                ST_HOLD: begin
                    r_state <= r_hold == 4'(HOLDOFF) ? ST_IDLE : ST_HOLD;
                    r_hold  <= r_hold + 4'd1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
endmodule

// File: tb/tb_gate_request_queue.sv
// tb_gate_request_queue: directed scenarios with hand-computed expectations for gate_request_queue
module tb_gate_request_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    always #5 clk = ~clk;
    gate_request_queue_if #(.DEPTH(4)) bus ();
    gate_request_queue #(.DEPTH(4), .HOLDOFF(2)) dut (
        .i_clock  (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    task automatic test_reset();
        #2;
        checks++; if (bus.queue_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", bus.queue_count); end
        checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_flags: got empty=%b full=%b ready=%b expected 1 0 1", bus.empty, bus.full, bus.req_ready); end
        checks++; if ({bus.in_mode, bus.out_mode, bus.reject} !== 3'b000 || bus.license_plate !== 16'h0) begin failures++; $display("FAIL reset_outputs: got in=%b out=%b rej=%b plate=%h expected 0 0 0 0000", bus.in_mode, bus.out_mode, bus.reject, bus.license_plate); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        bus.req_valid = 1'b1; bus.req_dir = 1'b0; bus.req_plate = 16'h9423;
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++; if (bus.queue_count !== 3'd1 || bus.in_mode !== 1'b0) begin failures++; $display("FAIL single_queued: got count=%0d in=%b expected 1 0", bus.queue_count, bus.in_mode); end
        @(negedge clk);
        checks++; if (bus.in_mode !== 1'b1 || bus.out_mode !== 1'b0 || bus.license_plate !== 16'h9423) begin failures++; $display("FAIL single_pulse: got in=%b out=%b plate=%h expected 1 0 9423", bus.in_mode, bus.out_mode, bus.license_plate); end
        checks++; if (bus.queue_count !== 3'd0 || bus.empty !== 1'b1) begin failures++; $display("FAIL single_drain: got count=%0d empty=%b expected 0 1", bus.queue_count, bus.empty); end
        @(negedge clk);
        checks++; if (bus.in_mode !== 1'b0 || bus.license_plate !== 16'h0) begin failures++; $display("FAIL single_end: got in=%b plate=%h expected 0 0000", bus.in_mode, bus.license_plate); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] plates [5] = '{16'h9423, 16'h8754, 16'h3891, 16'h7956, 16'h9706};
        int k = 1;
        int last = 0;
        bus.lot_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, bus.req_ready); end
            bus.req_valid = 1'b1; bus.req_dir = 1'b0; bus.req_plate = plates[i];
            @(negedge clk);
        end
        bus.req_plate = plates[4];
        checks++; if (bus.req_ready !== 1'b0 || bus.full !== 1'b1 || bus.queue_count !== 3'd4) begin failures++; $display("FAIL b2b_full: got ready=%b full=%b count=%0d expected 0 1 4", bus.req_ready, bus.full, bus.queue_count); end
        @(negedge clk);
        checks++; if (bus.queue_count !== 3'd4 || bus.in_mode !== 1'b0) begin failures++; $display("FAIL b2b_held: got count=%0d in=%b expected 4 0", bus.queue_count, bus.in_mode); end
        bus.lot_busy = 1'b0;
        @(negedge clk);
        checks++; if (bus.queue_count !== 3'd3 || bus.req_ready !== 1'b1) begin failures++; $display("FAIL b2b_pop_blocks_push: got count=%0d ready=%b expected 3 1", bus.queue_count, bus.req_ready); end
        checks++; if (bus.in_mode !== 1'b1 || bus.license_plate !== plates[0]) begin failures++; $display("FAIL b2b_pulse_0: got in=%b plate=%h expected 1 %h", bus.in_mode, bus.license_plate, plates[0]); end
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++; if (bus.queue_count !== 3'd4) begin failures++; $display("FAIL b2b_late_push: got count=%0d expected 4", bus.queue_count); end
        for (int i = 2; i < 30; i++) begin
            @(negedge clk);
            if (bus.in_mode || bus.out_mode) begin
                checks++; if (k > 4 || bus.out_mode !== 1'b0 || bus.license_plate !== plates[k > 4 ? 4 : k]) begin failures++; $display("FAIL b2b_pulse_%0d: got out=%b plate=%h expected 0 %h", k, bus.out_mode, bus.license_plate, plates[k > 4 ? 4 : k]); end
                checks++; if (i - last !== 4) begin failures++; $display("FAIL b2b_spacing_%0d: got %0d expected 4", k, i - last); end
                last = i;
                k++;
            end
        end
        checks++; if (k !== 5 || bus.empty !== 1'b1) begin failures++; $display("FAIL b2b_total: got pulses=%0d empty=%b expected 5 1", k, bus.empty); end
    endtask

    task automatic test_malformed();
        logic [15:0] bad [3] = '{16'hA123, 16'h0000, 16'h123F};
        for (int i = 0; i < 3; i++) begin
            bus.req_valid = 1'b1; bus.req_dir = 1'b0; bus.req_plate = bad[i];
            @(negedge clk);
            bus.req_valid = 1'b0;
            checks++; if (bus.reject !== 1'b1 || bus.queue_count !== 3'd0) begin failures++; $display("FAIL bad_%h_reject: got reject=%b count=%0d expected 1 0", bad[i], bus.reject, bus.queue_count); end
            @(negedge clk);
            checks++; if (bus.reject !== 1'b0 || bus.in_mode !== 1'b0 || bus.out_mode !== 1'b0) begin failures++; $display("FAIL bad_%h_after: got reject=%b in=%b out=%b expected 0 0 0", bad[i], bus.reject, bus.in_mode, bus.out_mode); end
        end
    endtask

    task automatic test_leakage();
        bus.leakage = 1'b1;
        bus.req_valid = 1'b1; bus.req_dir = 1'b1; bus.req_plate = 16'h7723;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            checks++; if (bus.out_mode !== 1'b0 || bus.queue_count !== 3'd1) begin failures++; $display("FAIL leak_hold_%0d: got out=%b count=%0d expected 0 1", i, bus.out_mode, bus.queue_count); end
            @(negedge clk);
        end
        bus.leakage = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_mode !== 1'b1 || bus.in_mode !== 1'b0 || bus.license_plate !== 16'h7723) begin failures++; $display("FAIL leak_release: got out=%b in=%b plate=%h expected 1 0 7723", bus.out_mode, bus.in_mode, bus.license_plate); end
        @(negedge clk);
        checks++; if (bus.out_mode !== 1'b0) begin failures++; $display("FAIL leak_one_cycle: got out=%b expected 0", bus.out_mode); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        bus.lot_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = 1'b1; bus.req_dir = 1'b0; bus.req_plate = 16'h1111 * 16'(i + 1);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        bus.lot_busy = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_mode !== 1'b1 || bus.queue_count !== 3'd3 || bus.license_plate !== 16'h1111) begin failures++; $display("FAIL rmid_issue: got in=%b count=%0d plate=%h expected 1 3 1111", bus.in_mode, bus.queue_count, bus.license_plate); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.in_mode !== 1'b0 || bus.empty !== 1'b1 || bus.queue_count !== 3'd0 || bus.license_plate !== 16'h0) begin failures++; $display("FAIL rmid_flush: got in=%b empty=%b count=%0d plate=%h expected 0 1 0 0000", bus.in_mode, bus.empty, bus.queue_count, bus.license_plate); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.in_mode || bus.out_mode) pulses++;
        end
        checks++; if (pulses !== 0 || bus.empty !== 1'b1) begin failures++; $display("FAIL rmid_quiet: got pulses=%0d empty=%b expected 0 1", pulses, bus.empty); end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_dir = 1'b0; bus.req_plate = 16'h0;
        bus.lot_busy = 1'b0; bus.leakage = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_malformed();
        test_leakage();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
